// File: rtl/read_order_gate.sv
// read_order_gate: AXI read ordering gate. Read data is only forwarded
// upstream when its ID matches the oldest outstanding read, so responses
// always come back in address-issue order without any reorder storage.
// Optional feature macro: RD_ORDER_LEN_CHECK_EN enables the burst length
// check that drives len_err; without it len_err is tied low.
module read_order_gate #(
  parameter int PID_WIDTH     = 4,
  parameter int PADDR_WIDTH   = 32,
  parameter int PLENGTH_WIDTH = 8,
  parameter int PSIZE_WIDTH   = 3,
  parameter int PDATA_WIDTH   = 4,
  parameter int DEPTH         = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PID_WIDTH-1:0]       s_arid,
  input  logic [PADDR_WIDTH-1:0]     s_araddr,
  input  logic [PLENGTH_WIDTH-1:0]   s_arlen,
  input  logic [PSIZE_WIDTH-1:0]     s_arsize,
  input  logic [1:0]                 s_arburst,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  output logic [PID_WIDTH-1:0]       m_arid,
  output logic [PADDR_WIDTH-1:0]     m_araddr,
  output logic [PLENGTH_WIDTH-1:0]   m_arlen,
  output logic [PSIZE_WIDTH-1:0]     m_arsize,
  output logic [1:0]                 m_arburst,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  input  logic [PID_WIDTH-1:0]       m_rid,
  input  logic [8*PDATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rlast,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  output logic [PID_WIDTH-1:0]       s_rid,
  output logic [8*PDATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                 s_rresp,
  output logic                       s_rlast,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic [$clog2(DEPTH):0]     outstanding,
  output logic                       len_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_t;

  logic [PID_WIDTH-1:0]     idMem_q [DEPTH];
  logic [PW-1:0]            wrPtr_q;
  logic [PW-1:0]            rdPtr_q;
  logic [CW-1:0]            count_q;
  logic [CW-1:0]            count_d;
  logic [PLENGTH_WIDTH-1:0] beatCnt_q;
  state_t                   state_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic rHs;
  logic headMatch;
  logic [PID_WIDTH-1:0] headId;

  // Full/empty come only from the registered count, which keeps s_rready
  // out of the combinational cone of m_arvalid.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign m_arid    = s_arid;
  assign m_araddr  = s_araddr;
  assign m_arlen   = s_arlen;
  assign m_arsize  = s_arsize;
  assign m_arburst = s_arburst;
  assign m_arvalid = s_arvalid & ~full;
  assign s_arready = m_arready & ~full;
  assign push      = m_arvalid & m_arready;

  assign headId    = idMem_q[rdPtr_q];
  assign headMatch = ~empty & (m_rid == headId);

  assign s_rid    = m_rid;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign s_rlast  = m_rlast;
  assign s_rvalid = m_rvalid & headMatch;
  assign m_rready = s_rready & headMatch;
  assign rHs      = m_rvalid & m_rready;
  assign pop      = rHs & m_rlast;

  assign outstanding = count_q;

  // Next outstanding count; a simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Order queue of IDs with pointers wrapping naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        idMem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        idMem_q[wrPtr_q] <= s_arid;
        wrPtr_q          <= wrPtr_q + PW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Head tracking FSM together with the beat counter of the current burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      beatCnt_q <= '0;
    end else begin
      if (rHs) begin
        beatCnt_q <= m_rlast ? '0 : beatCnt_q + PLENGTH_WIDTH'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (push) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (rHs && !m_rlast) begin
            state_q <= ST_BURST;
          end else if (pop && count_d == '0) begin
            state_q <= ST_IDLE;
          end
        end
        ST_BURST: begin
          if (pop) state_q <= (count_d == '0) ? ST_IDLE : ST_WAIT;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef RD_ORDER_LEN_CHECK_EN
  logic [PLENGTH_WIDTH-1:0] lenMem_q [DEPTH];
  logic [PLENGTH_WIDTH-1:0] headLen;
  logic                     lenMismatch;
  logic                     lenErr_q;

  assign headLen     = lenMem_q[rdPtr_q];
  assign lenMismatch = m_rlast ? (beatCnt_q != headLen) : (beatCnt_q == headLen);
  assign len_err     = lenErr_q;

  // Burst lengths stored alongside the IDs, written on the same push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        lenMem_q[i] <= '0;
      end
    end else if (push) begin
      lenMem_q[wrPtr_q] <= s_arlen;
    end
  end

  // One-cycle pulse when rlast arrives early/late relative to arlen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lenErr_q <= 1'b0;
    end else begin
      lenErr_q <= rHs & lenMismatch;
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule
